// File: rtl/inst_fetch.sv
// Instruction fetch stage: assembles a 32-bit little-endian instruction from
// four byte reads and presents it to the IF/ID register together with its PC.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [23:0] buffer, buffer_nxt;
  logic [31:0] if_pc_nxt, if_inst_nxt;

  // Next-state and memory-request outputs; a redirect overrides everything.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    cnt_nxt     = cnt;
    buffer_nxt  = buffer;
    if_pc_nxt   = if_pc;
    if_inst_nxt = if_inst;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    stallreq_o  = 1'b0;

    if (state == S_FETCH) begin
      mem_req_o  = 1'b1;
      mem_addr_o = pc + {30'b0, cnt};
      stallreq_o = 1'b1;
    end

    if (branch_flag_i) begin
      // Any byte returned this cycle belongs to the abandoned stream.
      state_nxt   = S_FETCH;
      pc_nxt      = {branch_target_addr_i[31:2], 2'b00};
      cnt_nxt     = '0;
      buffer_nxt  = '0;
      if_pc_nxt   = '0;
      if_inst_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_FETCH;
          cnt_nxt   = '0;
        end
        S_FETCH: begin
          if (mem_ready_i) begin
            case (cnt)
              2'd0: begin
                buffer_nxt[7:0] = mem_data_i;
                cnt_nxt         = 2'd1;
              end
              2'd1: begin
                buffer_nxt[15:8] = mem_data_i;
                cnt_nxt          = 2'd2;
              end
              2'd2: begin
                buffer_nxt[23:16] = mem_data_i;
                cnt_nxt           = 2'd3;
              end
              default: begin
                if_inst_nxt = {mem_data_i, buffer};
                if_pc_nxt   = pc;
                state_nxt   = S_HOLD;
              end
            endcase
          end
        end
        S_HOLD: begin
          if (!stall[0]) begin
            pc_nxt      = pc + 32'd4;
            cnt_nxt     = '0;
            buffer_nxt  = '0;
            if_pc_nxt   = '0;
            if_inst_nxt = '0;
            state_nxt   = S_FETCH;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State, PC, byte counter, partial buffer and delivered instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      cnt     <= '0;
      buffer  <= '0;
      if_pc   <= '0;
      if_inst <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      cnt     <= cnt_nxt;
      buffer  <= buffer_nxt;
      if_pc   <= if_pc_nxt;
      if_inst <= if_inst_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios plus a randomized run, all
// checked against a transaction-level model of the fetch stage.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_addr_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i = 1'b0;
  logic [7:0]  mem_data_i = '0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_o;

  int vec  = 0;
  int miss = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall                (stall),
    .branch_flag_i        (branch_flag_i),
    .branch_target_addr_i (branch_target_addr_i),
    .mem_req_o            (mem_req_o),
    .mem_addr_o           (mem_addr_o),
    .mem_ready_i          (mem_ready_i),
    .mem_data_i           (mem_data_i),
    .if_pc                (if_pc),
    .if_inst              (if_inst),
    .stallreq_o           (stallreq_o)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = waiting to start, 1 = collecting bytes,
  // 2 = presenting an instruction.
  int          m_mode;
  logic [31:0] m_pc;
  logic [7:0]  m_bytes[$];
  logic [31:0] m_if_pc, m_if_inst;

  function automatic void model_reset();
    m_mode    = 0;
    m_pc      = 32'h0000_0000;
    m_bytes.delete();
    m_if_pc   = '0;
    m_if_inst = '0;
  endfunction

  function automatic void model_update();
    if (branch_flag_i) begin
      m_pc = branch_target_addr_i & 32'hFFFF_FFFC;
      m_bytes.delete();
      m_if_pc = '0;
      m_if_inst = '0;
      m_mode = 1;
    end else if (m_mode == 0) begin
      m_bytes.delete();
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (mem_ready_i) begin
        m_bytes.push_back(mem_data_i);
        if (m_bytes.size() == 4) begin
          m_if_inst = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_if_pc   = m_pc;
          m_mode    = 2;
        end
      end
    end else if (!stall[0]) begin
      m_pc = m_pc + 32'd4;
      m_bytes.delete();
      m_if_pc = '0;
      m_if_inst = '0;
      m_mode = 1;
    end
  endfunction

  function automatic logic [97:0] model_outputs();
    logic        req;
    logic [31:0] addr;
    req  = (m_mode == 1);
    addr = req ? m_pc + 32'(m_bytes.size()) : 32'h0;
    return {req, addr, req, m_if_pc, m_if_inst};
  endfunction

  // Advance one clock: the model sees the inputs at the rising edge,
  // then control returns at the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    vec++;
    if ({mem_req_o, mem_addr_o, stallreq_o, if_pc, if_inst} !== 98'h0) begin
      miss++;
      $display("FAIL reset_async: got req=%0b addr=%h stallreq=%0b pc=%h inst=%h, want all zero",
               mem_req_o, mem_addr_o, stallreq_o, if_pc, if_inst);
    end
    model_reset();
    @(negedge clk);
    tick();
    vec++;
    if ({mem_req_o, mem_addr_o, stallreq_o, if_pc, if_inst} !== 98'h0) begin
      miss++;
      $display("FAIL reset_held: got req=%0b addr=%h stallreq=%0b pc=%h inst=%h, want all zero",
               mem_req_o, mem_addr_o, stallreq_o, if_pc, if_inst);
    end
  endtask

  task automatic test_basic_fetch();
    logic [7:0] b [4];
    b[0] = 8'h13; b[1] = 8'h00; b[2] = 8'h00; b[3] = 8'h00;
    rst = 1'b1;
    tick();
    for (int unsigned i = 0; i < 4; i++) begin
      vec++;
      if (mem_req_o !== 1'b1 || stallreq_o !== 1'b1 || mem_addr_o !== 32'(i) || if_inst !== 32'h0) begin
        miss++;
        $display("FAIL basic_addr%0d: got req=%0b stallreq=%0b addr=%h inst=%h, want 1 1 %h 0",
                 i, mem_req_o, stallreq_o, mem_addr_o, if_inst, 32'(i));
      end
      mem_ready_i = 1'b1;
      mem_data_i  = b[i];
      tick();
    end
    mem_ready_i = 1'b0;
    vec++;
    if (if_inst !== 32'h0000_0013 || if_pc !== 32'h0 || mem_req_o !== 1'b0 ||
        stallreq_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      miss++;
      $display("FAIL basic_deliver: got inst=%h pc=%h req=%0b stallreq=%0b addr=%h, want 00000013 0 0 0 0",
               if_inst, if_pc, mem_req_o, stallreq_o, mem_addr_o);
    end
  endtask

  task automatic test_wait_states();
    logic [7:0] b [4];
    for (int unsigned i = 0; i < 4; i++) b[i] = 8'($urandom);
    stall = 6'h00;
    tick();
    for (int unsigned i = 0; i < 2; i++) begin
      mem_ready_i = 1'b1; mem_data_i = b[i];
      tick();
    end
    mem_ready_i = 1'b0; mem_data_i = 8'hA5;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      vec++;
      if (mem_addr_o !== 32'h6 || mem_req_o !== 1'b1) begin
        miss++;
        $display("FAIL wait_addr%0d: got addr=%h req=%0b, want 00000006 1", i, mem_addr_o, mem_req_o);
      end
    end
    for (int unsigned i = 2; i < 4; i++) begin
      mem_ready_i = 1'b1; mem_data_i = b[i];
      tick();
    end
    mem_ready_i = 1'b0;
    vec++;
    if (if_inst !== {b[3], b[2], b[1], b[0]} || if_pc !== 32'h4) begin
      miss++;
      $display("FAIL wait_word: got inst=%h pc=%h, want %h 00000004",
               if_inst, if_pc, {b[3], b[2], b[1], b[0]});
    end
  endtask

  task automatic test_stall_hold();
    logic [31:0] inst_q;
    inst_q = if_inst;
    stall = 6'h01;
    for (int unsigned i = 0; i < 5; i++) begin
      mem_ready_i = 1'(i & 1); mem_data_i = 8'($urandom);
      tick();
      vec++;
      if (if_inst !== inst_q || if_pc !== 32'h4 || mem_req_o !== 1'b0 || stallreq_o !== 1'b0) begin
        miss++;
        $display("FAIL stall_hold%0d: got inst=%h pc=%h req=%0b stallreq=%0b, want %h 00000004 0 0",
                 i, if_inst, if_pc, mem_req_o, stallreq_o, inst_q);
      end
    end
    stall = 6'h00; mem_ready_i = 1'b0;
    tick();
    vec++;
    if (mem_addr_o !== 32'h8 || mem_req_o !== 1'b1 || if_inst !== 32'h0 || if_pc !== 32'h0) begin
      miss++;
      $display("FAIL stall_release: got addr=%h req=%0b inst=%h pc=%h, want 00000008 1 0 0",
               mem_addr_o, mem_req_o, if_inst, if_pc);
    end
  endtask

  task automatic test_branch();
    logic [7:0] b [4];
    for (int unsigned i = 0; i < 4; i++) b[i] = 8'($urandom);
    for (int unsigned i = 0; i < 2; i++) begin
      mem_ready_i = 1'b1; mem_data_i = 8'hC0 + 8'(i);
      tick();
    end
    branch_flag_i = 1'b1; branch_target_addr_i = 32'h0000_1006;
    mem_ready_i = 1'b1; mem_data_i = 8'hEE;
    tick();
    branch_flag_i = 1'b0;
    vec++;
    if (mem_addr_o !== 32'h0000_1004 || mem_req_o !== 1'b1) begin
      miss++;
      $display("FAIL branch_redirect: got addr=%h req=%0b, want 00001004 1", mem_addr_o, mem_req_o);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      mem_data_i = b[i];
      tick();
    end
    mem_ready_i = 1'b0;
    vec++;
    if (if_pc !== 32'h0000_1004 || if_inst !== {b[3], b[2], b[1], b[0]}) begin
      miss++;
      $display("FAIL branch_word: got pc=%h inst=%h, want 00001004 %h",
               if_pc, if_inst, {b[3], b[2], b[1], b[0]});
    end
  endtask

  task automatic test_wrap();
    stall = 6'h01;
    branch_flag_i = 1'b1; branch_target_addr_i = 32'hFFFF_FFFE;
    tick();
    branch_flag_i = 1'b0;
    mem_ready_i = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      mem_data_i = 8'($urandom);
      tick();
    end
    mem_ready_i = 1'b0;
    vec++;
    if (if_pc !== 32'hFFFF_FFFC) begin
      miss++;
      $display("FAIL wrap_pc: got pc=%h, want fffffffc", if_pc);
    end
    stall = 6'h00;
    tick();
    for (int unsigned i = 0; i < 4; i++) begin
      vec++;
      if (mem_addr_o !== 32'(i) || mem_req_o !== 1'b1) begin
        miss++;
        $display("FAIL wrap_addr%0d: got addr=%h req=%0b, want %h 1", i, mem_addr_o, mem_req_o, 32'(i));
      end
      mem_ready_i = 1'b1; mem_data_i = 8'($urandom);
      tick();
    end
    mem_ready_i = 1'b0;
  endtask

  task automatic test_async_reset();
    tick();
    mem_ready_i = 1'b1; mem_data_i = 8'h5A;
    tick();
    mem_ready_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    vec++;
    if ({mem_req_o, mem_addr_o, stallreq_o, if_pc, if_inst} !== 98'h0) begin
      miss++;
      $display("FAIL reset_midfetch: got req=%0b addr=%h stallreq=%0b pc=%h inst=%h, want all zero",
               mem_req_o, mem_addr_o, stallreq_o, if_pc, if_inst);
    end
    model_reset();
    @(negedge clk);
    tick();
    rst = 1'b1;
    tick();
    vec++;
    if (mem_addr_o !== 32'h0 || mem_req_o !== 1'b1 || if_inst !== 32'h0 || if_pc !== 32'h0) begin
      miss++;
      $display("FAIL reset_restart: got addr=%h req=%0b inst=%h pc=%h, want 0 1 0 0",
               mem_addr_o, mem_req_o, if_inst, if_pc);
    end
  endtask

  task automatic test_random();
    logic [97:0] exp;
    for (int unsigned n = 0; n < 800; n++) begin
      exp = model_outputs();
      vec++;
      if ({mem_req_o, mem_addr_o, stallreq_o, if_pc, if_inst} !== exp) begin
        miss++;
        $display("FAIL random_cyc%0d: got req=%0b addr=%h sr=%0b pc=%h inst=%h, want req=%0b addr=%h sr=%0b pc=%h inst=%h",
                 n, mem_req_o, mem_addr_o, stallreq_o, if_pc, if_inst,
                 exp[97], exp[96:65], exp[64], exp[63:32], exp[31:0]);
      end
      mem_ready_i          = ($urandom_range(0, 9) < 6);
      mem_data_i           = 8'($urandom);
      stall                = 6'($urandom);
      branch_flag_i        = ($urandom_range(0, 24) == 0);
      branch_target_addr_i = $urandom;
      tick();
    end
    branch_flag_i = 1'b0;
    mem_ready_i   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_stall_hold();
    test_branch();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
